// File: rtl/gpu_pkg.sv
// Shared GPU register-ring definitions: register offsets, command opcodes,
// the sequencer's command record and its FSM states.
package gpu_pkg;

  localparam logic [7:0] GPU_ADDR_PREFIX_DEF = 8'h7F;

  localparam logic [7:0] OFF_STATUS    = 8'h00;
  localparam logic [7:0] OFF_CTRL      = 8'h01;
  localparam logic [7:0] OFF_IMEM_ADDR = 8'h10;
  localparam logic [7:0] OFF_IMEM_DATA = 8'h11;
  localparam logic [7:0] OFF_DMEM_ADDR = 8'h20;
  localparam logic [7:0] OFF_DMEM_DATA = 8'h24;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_POLL = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  off;
    logic [31:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/gpu_reg_sequencer_if.sv
// Command/response handshake plus register-ring request and return signals.
// master = the sequencer, slave = controller and ring.
interface gpu_reg_sequencer_if #(
  parameter int UDP_REG_SRC_WIDTH = 2
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [7:0]                   cmd_off;
  logic [31:0]                  cmd_data;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [31:0]                  rsp_data;
  logic                         rsp_err;
  logic                         busy;
  logic                         reg_req_out;
  logic                         reg_rd_wr_L_out;
  logic [22:0]                  reg_addr_out;
  logic [31:0]                  reg_data_out;
  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out;
  logic                         reg_req_ret;
  logic                         reg_ack_ret;
  logic [31:0]                  reg_data_ret;

  modport master (
    input  cmd_valid, cmd_op, cmd_off, cmd_data, rsp_ready,
           reg_req_ret, reg_ack_ret, reg_data_ret,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
           reg_req_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_off, cmd_data, rsp_ready,
           reg_req_ret, reg_ack_ret, reg_data_ret,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
           reg_req_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );
endinterface

// File: rtl/gpu_cmd_fifo.sv
// First-word-fall-through command FIFO; head entry is visible on rdata_o
// whenever empty_o is low. DEPTH must be a power of two.
module gpu_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 42
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gpu_reg_sequencer.sv
// Host-side register command sequencer: queues WR/RD/POLL commands and
// replays them one at a time on the UDP register ring, one response each.
module gpu_reg_sequencer
  import gpu_pkg::*;
#(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [7:0]                   GPU_ADDR_PREFIX   = GPU_ADDR_PREFIX_DEF,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = UDP_REG_SRC_WIDTH'(1),
  parameter int                           FIFO_DEPTH        = 8,
  parameter int                           ACK_TIMEOUT       = 16,
  parameter int                           POLL_MAX          = 1024,
  parameter int                           POLL_GAP          = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  gpu_reg_sequencer_if.master bus
);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);

  seq_state_e                   state_q;
  cmd_t                         head;
  logic                         fifo_full, fifo_empty, pop, acked;
  logic [1:0]                   op_q;
  logic [31:0]                  mask_q, last_q;
  logic                         req_q, rd_wr_q;
  logic [22:0]                  addr_q;
  logic [31:0]                  wdata_q;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q;
  logic [ACK_W-1:0]             ack_cnt_q;
  logic [POLL_W-1:0]            poll_cnt_q;
  logic [GAP_W-1:0]             gap_cnt_q;
  logic                         rsp_valid_q, rsp_err_q;
  logic [31:0]                  rsp_data_q;

  assign pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign acked = bus.reg_req_ret && bus.reg_ack_ret;

  gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.cmd_valid),
    .pop_i   (pop),
    .wdata_i ({bus.cmd_op, bus.cmd_off, bus.cmd_data}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      mask_q      <= '0;
      last_q      <= '0;
      req_q       <= 1'b0;
      rd_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      src_q       <= '0;
      ack_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          op_q       <= head.op;
          mask_q     <= head.data;
          last_q     <= '0;
          ack_cnt_q  <= '0;
          poll_cnt_q <= '0;
          addr_q     <= {GPU_ADDR_PREFIX, 7'd0, head.off};
          rd_wr_q    <= (head.op != OP_WR);
          wdata_q    <= (head.op == OP_WR) ? head.data : '0;
          src_q      <= SRC_ID;
          if (head.op == OP_RSV) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
          end else begin
            req_q   <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (acked) begin
            req_q  <= 1'b0;
            last_q <= bus.reg_data_ret;
            if (op_q == OP_POLL && (bus.reg_data_ret & mask_q) == '0) begin
              if (poll_cnt_q == POLL_LAST) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_data_q  <= bus.reg_data_ret;
                state_q     <= ST_RESP;
              end else begin
                poll_cnt_q <= poll_cnt_q + 1'b1;
                gap_cnt_q  <= '0;
                state_q    <= ST_GAP;
              end
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= (op_q == OP_WR) ? '0 : bus.reg_data_ret;
              state_q     <= ST_RESP;
            end
          end else if (ack_cnt_q == ACK_LAST) begin
            // Abort: any later ack is ignored because req is already low.
            req_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= (op_q == OP_WR) ? '0 : last_q;
            state_q     <= ST_RESP;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            req_q     <= 1'b1;
            ack_cnt_q <= '0;
            state_q   <= ST_ISSUE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready       = ~fifo_full;
  assign bus.busy            = ~fifo_empty || (state_q != ST_IDLE);
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.reg_req_out     = req_q;
  assign bus.reg_rd_wr_L_out = rd_wr_q;
  assign bus.reg_addr_out    = addr_q;
  assign bus.reg_data_out    = wdata_q;
  assign bus.reg_src_out     = src_q;

endmodule

// File: tb/tb_gpu_reg_sequencer.sv
// Directed bench for gpu_reg_sequencer with a small register-ring responder.
module tb_gpu_reg_sequencer;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  gpu_reg_sequencer_if #(.UDP_REG_SRC_WIDTH(2)) bus ();

  gpu_reg_sequencer #(
    .UDP_REG_SRC_WIDTH (2),
    .GPU_ADDR_PREFIX   (8'h7F),
    .SRC_ID            (2'd1),
    .FIFO_DEPTH        (8),
    .ACK_TIMEOUT       (16),
    .POLL_MAX          (1024),
    .POLL_GAP          (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Ring responder: acks in the same cycle as req unless ack_en is low.
  logic        ack_en = 1'b1, late_ack = 1'b0, pmode = 1'b0, rmode = 1'b0;
  logic [31:0] ret_val = '0, ret_data;
  logic [31:0] pseq [3] = '{32'd1, 32'd1, 32'd2};
  int          rises = 0, req_cyc = 0, low_run = 0, last_gap = 0, pbase = 0;
  logic        req_prev = 1'b0;

  assign bus.reg_req_ret  = (bus.reg_req_out & ack_en) | late_ack;
  assign bus.reg_ack_ret  = (bus.reg_req_out & ack_en) | late_ack;
  assign bus.reg_data_ret = ret_data;

  always_comb begin
    ret_data = ret_val;
    if (rmode) ret_data = {24'hC0DE00, bus.reg_addr_out[7:0]};
    else if (pmode) ret_data = (rises - pbase >= 2) ? pseq[2] : pseq[rises - pbase];
  end

  always @(posedge clk) begin
    if (bus.reg_req_out) begin
      req_cyc <= req_cyc + 1;
      if (!req_prev) begin
        rises    <= rises + 1;
        last_gap <= low_run;
      end
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
    req_prev <= bus.reg_req_out;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] off, input logic [31:0] data);
    int n = 0;
    bus.cmd_op    = op;
    bus.cmd_off   = off;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push accepted", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Assumes rsp_ready is high, so the response is consumed at the next edge.
  task automatic wait_rsp(input string tag, output logic [31:0] d, output logic e);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    d = bus.rsp_data;
    e = bus.rsp_err;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          r0, c0, n, seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_off   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    chk("rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst rsp_data",  bus.rsp_data, 32'd0);
    chk("rst rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst req",       {31'd0, bus.reg_req_out}, 32'd0);
    chk("rst rd_wr",     {31'd0, bus.reg_rd_wr_L_out}, 32'd0);
    chk("rst addr",      {9'd0, bus.reg_addr_out}, 32'd0);
    chk("rst wdata",     bus.reg_data_out, 32'd0);
    chk("rst src",       {30'd0, bus.reg_src_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single write, ring acks in the same cycle.
    push(OP_WR, 8'h01, 32'h100);
    chk("wr req before issue", {31'd0, bus.reg_req_out}, 32'd0);
    chk("wr busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("wr req",   {31'd0, bus.reg_req_out}, 32'd1);
    chk("wr addr",  {9'd0, bus.reg_addr_out}, 32'h003F_8001);
    chk("wr data",  bus.reg_data_out, 32'h100);
    chk("wr rd_wr", {31'd0, bus.reg_rd_wr_L_out}, 32'd0);
    chk("wr src",   {30'd0, bus.reg_src_out}, 32'd1);
    @(negedge clk);
    chk("wr req dropped", {31'd0, bus.reg_req_out}, 32'd0);
    chk("wr rsp_valid",   {31'd0, bus.rsp_valid}, 32'd1);
    chk("wr rsp_data",    bus.rsp_data, 32'd0);
    chk("wr rsp_err",     {31'd0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    chk("wr rsp consumed", {31'd0, bus.rsp_valid}, 32'd0);
    chk("wr busy idle",    {31'd0, bus.busy}, 32'd0);

    // Read returning DEADBEEF; write data must not leak onto the ring.
    ret_val = 32'hDEADBEEF;
    push(OP_RD, 8'h24, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rd req",   {31'd0, bus.reg_req_out}, 32'd1);
    chk("rd rd_wr", {31'd0, bus.reg_rd_wr_L_out}, 32'd1);
    chk("rd wdata", bus.reg_data_out, 32'd0);
    chk("rd addr",  {9'd0, bus.reg_addr_out}, 32'h003F_8024);
    @(negedge clk);
    chk("rd rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rd rsp_data",  bus.rsp_data, 32'hDEADBEEF);
    chk("rd rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    @(negedge clk);

    // Reserved opcode: error response, nothing on the ring.
    r0 = rises;
    push(OP_RSV, 8'h05, 32'h1);
    wait_rsp("rsv", d, e);
    chk("rsv err",  {31'd0, e}, 32'd1);
    chk("rsv data", d, 32'd0);
    chk("rsv no ring req", rises - r0, 32'd0);

    // Poll bit 1; ring returns 1, 1, 2.
    pbase = rises;
    c0    = req_cyc;
    pmode = 1'b1;
    push(OP_POLL, 8'h00, 32'h2);
    wait_rsp("poll", d, e);
    pmode = 1'b0;
    chk("poll data",      d, 32'd2);
    chk("poll err",       {31'd0, e}, 32'd0);
    chk("poll reads",     rises - pbase, 32'd3);
    chk("poll req cycles", req_cyc - c0, 32'd3);
    chk("poll gap",       last_gap, 32'd4);

    // Fill the FIFO behind a stalled response, then drain in order.
    rmode = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(OP_RD, 8'h40 + 8'(i), 32'd0);
    chk("full cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("full busy",      {31'd0, bus.busy}, 32'd1);
    chk("full rsp stall", {31'd0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_rsp("drain", d, e);
      chk("drain data", d, {24'hC0DE00, 8'h40 + 8'(i)});
      chk("drain err",  {31'd0, e}, 32'd0);
    end
    chk("drain busy idle", {31'd0, bus.busy}, 32'd0);
    rmode = 1'b0;

    // No ack: 16-cycle timeout, late ack ignored.
    ack_en = 1'b0;
    bus.rsp_ready = 1'b0;
    c0 = req_cyc;
    push(OP_RD, 8'h10, 32'd0);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
    chk("tmo req cycles", req_cyc - c0, 32'd16);
    chk("tmo err",        {31'd0, bus.rsp_err}, 32'd1);
    chk("tmo data",       bus.rsp_data, 32'd0);
    chk("tmo req low",    {31'd0, bus.reg_req_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo rsp consumed", {31'd0, bus.rsp_valid}, 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    chk("tmo no extra rsp", seen, 32'd0);
    chk("tmo busy idle", {31'd0, bus.busy}, 32'd0);

    // Reset while a request is outstanding.
    push(OP_RD, 8'h30, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid req high", {31'd0, bus.reg_req_out}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst req",       {31'd0, bus.reg_req_out}, 32'd0);
    chk("mid rst busy",      {31'd0, bus.busy}, 32'd0);
    chk("mid rst cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("mid rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 || bus.reg_req_out === 1'b1) seen++;
    end
    chk("post rst quiet", seen, 32'd0);
    chk("post rst busy",  {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
